// File: rtl/axi_lite_reg_master.sv
// AXI4-Lite initiator: turns single-beat register commands from a local
// controller into AXI4-Lite reads or writes, one transaction at a time,
// with a per-phase watchdog that aborts a stalled transaction.
module axi_lite_reg_master #(
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDRESS     = '0,
    parameter int                            C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int CW = $clog2(C_TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                            awDone_q, awDone_d;
    logic                            wDone_q, wDone_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]                      resp_q, resp_d;
    logic                            timeout_q, timeout_d;

    logic          cmdHs, awHs, wHs, bHs, arHs, rHs;
    logic          timeoutHit;
    logic [CW-1:0] cntInc;

    assign cmdHs      = cmd_valid && cmd_ready;
    assign awHs       = M_AXI_AWVALID && M_AXI_AWREADY;
    assign wHs        = M_AXI_WVALID && M_AXI_WREADY;
    assign bHs        = M_AXI_BVALID && M_AXI_BREADY;
    assign arHs       = M_AXI_ARVALID && M_AXI_ARREADY;
    assign rHs        = M_AXI_RVALID && M_AXI_RREADY;
    assign timeoutHit = (cnt_q == CW'(C_TIMEOUT_CYCLES - 1));
    assign cntInc     = timeoutHit ? cnt_q : cnt_q + CW'(1);

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awDone_q  <= 1'b0;
            wDone_q   <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awDone_q  <= awDone_d;
            wDone_q   <= wDone_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state: phase sequencing, response capture and watchdog abort
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awDone_d  = awDone_q;
        wDone_d   = wDone_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (cmdHs) begin
                    addr_d    = cmd_addr ^ C_BASE_ADDRESS;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    cnt_d     = '0;
                    awDone_d  = 1'b0;
                    wDone_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = cmd_write ? WR : RD_AR;
                end
            end
            WR: begin
                awDone_d = awDone_q || awHs;
                wDone_d  = wDone_q || wHs;
                if (awDone_d && wDone_d) begin
                    state_d = WR_B;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cntInc;
                end
            end
            WR_B: begin
                if (bHs) begin
                    resp_d  = M_AXI_BRESP;
                    rdata_d = '0;
                    state_d = RSP;
                end else begin
                    cnt_d = cntInc;
                end
            end
            RD_AR: begin
                if (arHs) begin
                    state_d = RD_R;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cntInc;
                end
            end
            RD_R: begin
                if (rHs) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    state_d = RSP;
                end else begin
                    cnt_d = cntInc;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if ((state_d == state_q) && timeoutHit &&
            (state_q == WR || state_q == WR_B || state_q == RD_AR || state_q == RD_R)) begin
            state_d   = RSP;
            rdata_d   = C_M_AXI_DATA_WIDTH'(32'hDEADBEEF);
            resp_d    = 2'b10;
            timeout_d = 1'b1;
        end
    end

    // Outputs decoded from the current state and the latched command
    always_comb begin
        cmd_ready     = (state_q == IDLE) && !reset;
        M_AXI_AWVALID = (state_q == WR) && !awDone_q;
        M_AXI_WVALID  = (state_q == WR) && !wDone_q;
        M_AXI_BREADY  = (state_q == WR_B);
        M_AXI_ARVALID = (state_q == RD_AR);
        M_AXI_RREADY  = (state_q == RD_R);
        rsp_valid     = (state_q == RSP);
        rsp_rdata     = rdata_q;
        rsp_resp      = resp_q;
        rsp_timeout   = timeout_q;
        M_AXI_AWADDR  = addr_q;
        M_AXI_ARADDR  = addr_q;
        M_AXI_WDATA   = wdata_q;
        M_AXI_WSTRB   = wstrb_q;
    end

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// Directed bench for axi_lite_reg_master with a small AXI4-Lite slave model
// and a response scoreboard.
module tb_axi_lite_reg_master;

    localparam logic [31:0] BASE    = 32'h4400_0000;
    localparam int          TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    axi_lite_reg_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(32),
        .C_BASE_ADDRESS    (BASE),
        .C_TIMEOUT_CYCLES  (TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to measure response latency
    int cycleCount = 0;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Slave behaviour knobs, set by the stimulus
    int          awDelay = 0, wDelay = 0, arDelay = 0;
    bit          arNever = 1'b0, bStall = 1'b0;
    logic [1:0]  bRespCfg = 2'b00, rRespCfg = 2'b00;
    logic [31:0] rDataCfg = 32'h0;

    int          awWait, wWait, arWait;
    logic        awDone, wDone;
    logic        awReadyS, wReadyS, bValidS, arReadyS, rValidS;
    logic [1:0]  bRespS, rRespS;
    logic [31:0] rDataS;
    logic        awHs, wHs, arHs;

    assign M_AXI_AWREADY = awReadyS;
    assign M_AXI_WREADY  = wReadyS;
    assign M_AXI_BVALID  = bValidS;
    assign M_AXI_BRESP   = bRespS;
    assign M_AXI_ARREADY = arReadyS;
    assign M_AXI_RVALID  = rValidS;
    assign M_AXI_RRESP   = rRespS;
    assign M_AXI_RDATA   = rDataS;
    assign awHs = awReadyS && M_AXI_AWVALID;
    assign wHs  = wReadyS && M_AXI_WVALID;
    assign arHs = arReadyS && M_AXI_ARVALID;

    // Register-slave model: READY pulses after a programmable wait, the
    // response is raised on the edge that completes the address/data phase
    always @(posedge clk) begin
        if (reset) begin
            awReadyS <= 1'b0; wReadyS <= 1'b0; bValidS <= 1'b0;
            arReadyS <= 1'b0; rValidS <= 1'b0;
            bRespS <= 2'b00; rRespS <= 2'b00; rDataS <= 32'h0;
            awWait <= 0; wWait <= 0; arWait <= 0;
            awDone <= 1'b0; wDone <= 1'b0;
        end else begin
            if (bValidS && M_AXI_BREADY) begin
                bValidS <= 1'b0; awDone <= 1'b0; wDone <= 1'b0;
                awWait <= 0; wWait <= 0;
            end else begin
                if (awHs) begin
                    awReadyS <= 1'b0; awDone <= 1'b1;
                end else if (M_AXI_AWVALID && !awReadyS && !awDone) begin
                    if (awWait >= awDelay) awReadyS <= 1'b1;
                    else awWait <= awWait + 1;
                end
                if (wHs) begin
                    wReadyS <= 1'b0; wDone <= 1'b1;
                end else if (M_AXI_WVALID && !wReadyS && !wDone) begin
                    if (wWait >= wDelay) wReadyS <= 1'b1;
                    else wWait <= wWait + 1;
                end
                if (!bValidS && !bStall && (awDone || awHs) && (wDone || wHs)) begin
                    bValidS <= 1'b1; bRespS <= bRespCfg;
                end
            end
            if (arHs) begin
                arReadyS <= 1'b0; rValidS <= 1'b1; rDataS <= rDataCfg; rRespS <= rRespCfg;
            end else if (M_AXI_ARVALID && !arReadyS && !arNever) begin
                if (arWait >= arDelay) arReadyS <= 1'b1;
                else arWait <= arWait + 1;
            end
            if (rValidS && M_AXI_RREADY) begin
                rValidS <= 1'b0; arWait <= 0;
            end
        end
    end

    // OR of every DUT output, used to confirm the all-zero reset state
    logic outputsBusy;
    assign outputsBusy = |{cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
                           M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB,
                           M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID,
                           M_AXI_RREADY};

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        timeout;
    } rspExp_t;

    rspExp_t sb[$];
    int      evaluated = 0;
    int      failures  = 0;
    int      hsCycle   = 0;

    // Single comparison point: counts every check and every failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        evaluated++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present a command and record the response it should produce
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input logic [31:0] expRdata, input logic [1:0] expResp,
                                 input logic expTimeout);
        rspExp_t e;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        e.rdata   = expRdata;
        e.resp    = expResp;
        e.timeout = expTimeout;
        sb.push_back(e);
    endtask

    // Wait for the command handshake; returns at the negedge of cycle 1
    task automatic waitAccept();
        bit accepted = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cmd_ready === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                cmd_valid = 1'b0;
                hsCycle   = cycleCount;
                accepted  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            cmd_valid = 1'b0;
            checkOutput("cmd_accept", 32'(accepted), 32'd1);
        end
    endtask

    // Wait for rsp_valid, then pop the scoreboard and compare the response
    task automatic waitResponse(output int lat);
        bit      found = 1'b0;
        rspExp_t e;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("rsp_arrives", 32'(found), 32'd1);
        if (found) begin
            lat = cycleCount - hsCycle + 1;
            if (sb.size() == 0) begin
                checkOutput("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
            end
        end
    endtask

    task automatic ackResponse();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_released", 32'(rsp_valid), 32'd0);
    endtask

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #300000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Directed sequence
    initial begin
        int lat;
        int awCount, wCount, bWindows, arCount;
        logic prevBready;

        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", 32'(outputsBusy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Zero-wait write: address and data together, 4-cycle latency
        applyStimulus(1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 32'h0, 2'b00, 1'b0);
        waitAccept();
        checkOutput("t1_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID}), 32'd3);
        checkOutput("t1_awaddr", M_AXI_AWADDR, 32'h10 ^ BASE);
        checkOutput("t1_wdata", M_AXI_WDATA, 32'hA5A5_0001);
        checkOutput("t1_wstrb", 32'(M_AXI_WSTRB), 32'hF);
        waitResponse(lat);
        checkOutput("t1_latency", 32'(lat), 32'd4);
        ackResponse();

        // WREADY three cycles ahead of AWREADY
        awDelay = 3;
        applyStimulus(1'b1, 32'h20, 32'h0BAD_F00D, 4'h3, 32'h0, 2'b00, 1'b0);
        waitAccept();
        awCount = 0; wCount = 0; bWindows = 0; prevBready = 1'b0;
        for (int i = 0; i < 30 && !rsp_valid; i++) begin
            if (M_AXI_AWVALID) awCount++;
            if (M_AXI_WVALID) wCount++;
            if (M_AXI_BREADY && !prevBready) bWindows++;
            prevBready = M_AXI_BREADY;
            @(negedge clk);
        end
        checkOutput("t2_awvalid_cycles", 32'(awCount), 32'd5);
        checkOutput("t2_wvalid_cycles", 32'(wCount), 32'd2);
        checkOutput("t2_bready_windows", 32'(bWindows), 32'd1);
        waitResponse(lat);
        checkOutput("t2_latency", 32'(lat), 32'd7);
        ackResponse();
        awDelay = 0;

        // Read with the base address folded in
        rDataCfg = 32'h1234;
        applyStimulus(1'b0, 32'h04, 32'h0, 4'h0, 32'h1234, 2'b00, 1'b0);
        waitAccept();
        checkOutput("t3_arvalid", 32'(M_AXI_ARVALID), 32'd1);
        checkOutput("t3_araddr", M_AXI_ARADDR, 32'h4400_0004);
        waitResponse(lat);
        checkOutput("t3_latency", 32'(lat), 32'd4);
        ackResponse();

        // Error responses pass through untouched
        rDataCfg = 32'hCAFE_0000; rRespCfg = 2'b10;
        applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 32'hCAFE_0000, 2'b10, 1'b0);
        waitAccept();
        waitResponse(lat);
        ackResponse();
        bRespCfg = 2'b11;
        applyStimulus(1'b1, 32'h0C, 32'h1, 4'h1, 32'h0, 2'b11, 1'b0);
        waitAccept();
        waitResponse(lat);
        ackResponse();
        bRespCfg = 2'b00; rRespCfg = 2'b00;

        // Response held while a second command waits
        rDataCfg = 32'h55AA;
        applyStimulus(1'b0, 32'h14, 32'h0, 4'h0, 32'h55AA, 2'b00, 1'b0);
        waitAccept();
        waitResponse(lat);
        applyStimulus(1'b1, 32'h30, 32'h77, 4'hF, 32'h0, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t5_rsp_valid_held", 32'(rsp_valid), 32'd1);
            checkOutput("t5_rdata_held", rsp_rdata, 32'h55AA);
            checkOutput("t5_cmd_blocked", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        checkOutput("t5_cmd_blocked_ack", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("t5_rsp_dropped", 32'(rsp_valid), 32'd0);
        checkOutput("t5_cmd_ready_after", 32'(cmd_ready), 32'd1);
        waitAccept();
        waitResponse(lat);
        checkOutput("t5_second_latency", 32'(lat), 32'd4);
        ackResponse();

        // Watchdog: ARREADY never comes
        arNever = 1'b1;
        applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b10, 1'b1);
        waitAccept();
        arCount = 0;
        for (int i = 0; i < 20 && M_AXI_ARVALID; i++) begin
            arCount++;
            @(negedge clk);
        end
        checkOutput("t4_arvalid_cycles", 32'(arCount), 32'd8);
        checkOutput("t4_arvalid_dropped", 32'(M_AXI_ARVALID), 32'd0);
        waitResponse(lat);
        checkOutput("t4_latency", 32'(lat), 32'd9);
        ackResponse();
        reset = 1'b1; arNever = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset while waiting for BVALID
        bStall = 1'b1;
        applyStimulus(1'b1, 32'h50, 32'h1111, 4'hF, 32'h0, 2'b00, 1'b0);
        waitAccept();
        for (int i = 0; i < 10 && !M_AXI_BREADY; i++) @(negedge clk);
        checkOutput("t6_in_wr_b", 32'(M_AXI_BREADY), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_reset_outputs", 32'(outputsBusy), 32'd0);
        reset = 1'b0; bStall = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t6_no_rsp", 32'(rsp_valid), 32'd0);
        end
        applyStimulus(1'b1, 32'h60, 32'h2222, 4'hF, 32'h0, 2'b00, 1'b0);
        waitAccept();
        checkOutput("t6_fresh_awaddr", M_AXI_AWADDR, 32'h60 ^ BASE);
        waitResponse(lat);
        checkOutput("t6_fresh_latency", 32'(lat), 32'd4);
        ackResponse();

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

endmodule
